sleep_ctrl: RTL
===============

SLEEP_CTRL -- requirements
Module: sleep_ctrl

Interface
REQ-001 The block SHALL have parameter WAKE_CYCLES, default 4, meaning power-up settle cycles between sleep deassertion and restore (legal 1..255).
REQ-002 The block SHALL have parameter IDLE_CYCLES, default 8, meaning consecutive idle cycles before auto-sleep entry (legal 1..255).
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sleep_req  input  1  level request to enter low-power mode.
REQ-006 wake_req  input  1  level request to exit low-power mode.
REQ-007 idle  input  1  gated domain reports no activity.
REQ-008 auto_en  input  1  enables idle-driven auto-sleep.
REQ-009 sleep  output  1  MTCMOS header/footer control to the gated flip-flops; 1 = power off.
REQ-010 iso  output  1  output isolation enable for the gated domain.
REQ-011 save  output  1  one-cycle retention save strobe.
REQ-012 restore  output  1  one-cycle retention restore strobe.
REQ-013 state  output  3  current FSM state encoding.
REQ-014 wake_done  output  1  one-cycle pulse when domain is fully active again.

Function
REQ-015 FSM states and encodings SHALL be ACTIVE=0, SAVE=1, ISOLATE=2, OFF=3, PWRUP=4, RESTORE=5, DEISO=6; all outputs registered.
REQ-016 ACTIVE: sleep=0, iso=0; transition to SAVE when (sleep_req=1 and wake_req=0) or auto-trigger (REQ-022).
REQ-017 SAVE: save=1 for exactly this one cycle, iso=0, sleep=0; next state ISOLATE unconditionally.
REQ-018 ISOLATE: iso=1, sleep=0; next state OFF unconditionally.
REQ-019 OFF: iso=1, sleep=1; remain until wake_req=1 or pending-wake flag set, then PWRUP; sleep_req ignored.
REQ-020 PWRUP: sleep=0, iso=1; 8-bit settle counter loads 0 on entry, increments each cycle; exit to RESTORE on the cycle counter equals WAKE_CYCLES-1 (PWRUP occupies exactly WAKE_CYCLES cycles).
REQ-021 RESTORE: restore=1 for exactly one cycle, iso=1; next DEISO. DEISO: iso=0, sleep=0, wake_done=1 for one cycle; next ACTIVE.
REQ-022 Idle counter (8-bit) SHALL count consecutive cycles with idle=1 and auto_en=1 in ACTIVE; clears on idle=0, auto_en=0, or leaving ACTIVE; auto-trigger when count reaches IDLE_CYCLES-1 with idle still 1; saturates, no wrap.
REQ-023 wake_req=1 sampled in SAVE or ISOLATE SHALL set a pending-wake flag; entry sequence completes, OFF held one cycle, then PWRUP; flag clears on entering PWRUP.
REQ-024 wake_req in PWRUP, RESTORE, DEISO, ACTIVE SHALL have no effect; sleep_req in any non-ACTIVE state SHALL have no effect.
REQ-025 Simultaneous sleep_req=1 and wake_req=1 in ACTIVE SHALL keep ACTIVE (wake priority); auto-trigger also suppressed while wake_req=1.
REQ-026 sleep=1 SHALL never be asserted unless iso=1 in the same cycle; iso SHALL deassert only after restore pulse.
REQ-027 Total latency sleep_req to sleep=1 SHALL be 3 cycles; wake_req (in OFF) to wake_done SHALL be WAKE_CYCLES+2 cycles.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=ACTIVE, sleep=0, iso=0, save=0, restore=0, wake_done=0, both counters=0, pending-wake=0, from any state including mid-sequence.
REQ-029 First transition out of ACTIVE SHALL be possible on the cycle after rst deasserts.

Verification
REQ-030 sleep_req pulse in ACTIVE -> save=1 cycle 1, iso=1 cycle 2, sleep=1 cycle 3, state=3 held.
REQ-031 WAKE_CYCLES=4, wake_req in OFF -> sleep=0 next cycle, restore pulse 4 cycles later, wake_done 1 cycle after, state=0, iso=0.
REQ-032 auto_en=1, idle=1 for 8 cycles (IDLE_CYCLES=8) -> SAVE entered; repeat with idle dropping at cycle 5 -> no entry, counter cleared.
REQ-033 sleep_req=1 and wake_req=1 same cycle in ACTIVE -> state stays 0, no save pulse.
REQ-034 wake_req pulse during SAVE -> OFF for exactly one cycle, then full wake sequence, wake_done asserted.
REQ-035 rst asserted during PWRUP -> next cycle state=0, sleep=0, iso=0, no restore/wake_done pulse.

Source files
------------

// File: rtl/sleep_ctrl.sv
// Power-gating sequencer for one switchable domain.
// Enters low power with save -> isolate -> power off. Leaves it with power up -> settle ->
// restore -> de-isolate. Entry is triggered by sleep_req or by a run of idle cycles.
//
// Parameters:
//   WAKE_CYCLES  power-up settle cycles spent in PWRUP (1..255)
//   IDLE_CYCLES  consecutive idle cycles before auto-sleep entry (1..255)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sleep_req  level request to enter low-power mode
//   wake_req   level request to exit low-power mode
//   idle       gated domain reports no activity
//   auto_en    enables idle-driven auto-sleep
//   sleep      power switch control, 1 = domain powered off
//   iso        output isolation enable
//   save       one-cycle retention save strobe
//   restore    one-cycle retention restore strobe
//   state      current FSM state encoding
//   wake_done  one-cycle pulse when the domain is fully active again
module sleep_ctrl #(
  parameter int unsigned WAKE_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       idle,
  input  logic       auto_en,
  output logic       sleep,
  output logic       iso,
  output logic       save,
  output logic       restore,
  output logic [2:0] state,
  output logic       wake_done
);

  typedef enum logic [2:0] {
    StActive  = 3'd0,
    StSave    = 3'd1,
    StIsolate = 3'd2,
    StOff     = 3'd3,
    StPwrup   = 3'd4,
    StRestore = 3'd5,
    StDeiso   = 3'd6
  } state_e;

  localparam logic [7:0] WakeLast = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] IdleLast = 8'(IDLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] settle_q;
  logic [7:0] idle_q;
  logic       pend_q;
  logic       idle_hit;
  logic       auto_trig;

  assign idle_hit  = idle && auto_en;
  // idle_q holds the number of earlier consecutive idle cycles; this cycle completes the run.
  assign auto_trig = idle_hit && (idle_q >= IdleLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      // wake_req has priority: it blocks both explicit and automatic entry.
      StActive:  if (!wake_req && (sleep_req || auto_trig)) state_d = StSave;
      StSave:    state_d = StIsolate;
      StIsolate: state_d = StOff;
      StOff:     if (wake_req || pend_q) state_d = StPwrup;
      StPwrup:   if (settle_q == WakeLast) state_d = StRestore;
      StRestore: state_d = StDeiso;
      StDeiso:   state_d = StActive;
      default:   state_d = StActive;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StActive;
      settle_q  <= 8'd0;
      idle_q    <= 8'd0;
      pend_q    <= 1'b0;
      sleep     <= 1'b0;
      iso       <= 1'b0;
      save      <= 1'b0;
      restore   <= 1'b0;
      wake_done <= 1'b0;
    end else begin
      state_q <= state_d;

      // Zero on entry to PWRUP, counts while staying there.
      if (state_q == StPwrup && state_d == StPwrup) settle_q <= settle_q + 8'd1;
      else                                          settle_q <= 8'd0;

      // Saturating run length of idle cycles; any break or leaving ACTIVE clears it.
      if (state_q == StActive && state_d == StActive && idle_hit) begin
        if (idle_q != 8'hff) idle_q <= idle_q + 8'd1;
      end else begin
        idle_q <= 8'd0;
      end

      // A wake arriving mid-entry is remembered so OFF is left right after it is reached.
      if ((state_q == StSave || state_q == StIsolate) && wake_req) pend_q <= 1'b1;
      else if (state_d == StPwrup)                                  pend_q <= 1'b0;

      sleep     <= (state_d == StOff);
      iso       <= (state_d == StIsolate) || (state_d == StOff) ||
                   (state_d == StPwrup) || (state_d == StRestore);
      save      <= (state_d == StSave);
      restore   <= (state_d == StRestore);
      wake_done <= (state_d == StDeiso);
    end
  end

  assign state = state_q;

endmodule
